// File: rtl/pattern_pkg.sv
// pattern_pkg: shared geometry, word width and FSM encoding for the mask
// pattern generator and reader.
package pattern_pkg;

   localparam int C_NUM_ROWS      = 160;
   localparam int C_WORDS_PER_ROW = 18;
   localparam int PAT_W           = 10;

   localparam logic [PAT_W-1:0] Pat_all1  = '1;
   localparam logic [PAT_W-1:0] Pat_Blank = '0;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_READ  = 5'b00010,
      S_DRAIN = 5'b00100,
      S_LATCH = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;

endpackage

// File: rtl/pattern_reader_if.sv
// pattern_reader_if: FIFO, imager mask and status signals of the pattern reader.
// The reader side takes the master modport.
interface pattern_reader_if;
   import pattern_pkg::*;

   logic             Subc_start;
   logic             FIFO_empty;
   logic [PAT_W-1:0] FIFO_dout;
   logic             FIFO_rd;
   logic [PAT_W-1:0] Mask_data;
   logic             Mask_wr;
   logic             Row_latch;
   logic             Subc_done;
   logic             Busy;
   logic             Underflow;
   logic [31:0]      CntSubc;

   modport master (
      input  Subc_start, FIFO_empty, FIFO_dout,
      output FIFO_rd, Mask_data, Mask_wr, Row_latch, Subc_done, Busy, Underflow, CntSubc
   );

   modport slave (
      output Subc_start, FIFO_empty, FIFO_dout,
      input  FIFO_rd, Mask_data, Mask_wr, Row_latch, Subc_done, Busy, Underflow, CntSubc
   );

endinterface

// File: rtl/pattern_reader.sv
// pattern_reader: pops one subframe of mask pattern words from the FIFO, writes
// them to the imager mask register and latches each completed row.
module pattern_reader
   import pattern_pkg::*;
#(
   parameter int C_NUM_ROWS      = pattern_pkg::C_NUM_ROWS,
   parameter int C_WORDS_PER_ROW = pattern_pkg::C_WORDS_PER_ROW
) (
   input  logic             clk,
   input  logic             rst,
   pattern_reader_if.master io
);

   localparam int RW = $clog2(C_NUM_ROWS);
   localparam int WW = $clog2(C_WORDS_PER_ROW);

   state_t           state_q;
   logic [RW-1:0]    row_q;
   logic [WW-1:0]    word_q;
   logic             drain_q;
   logic             rd_q;
   logic [PAT_W-1:0] mask_data_q;
   logic             mask_wr_q;
   logic             underflow_q;
   logic [31:0]      cnt_q;
   logic             fifo_rd;
   logic             last_word;

   assign fifo_rd   = (state_q == S_READ) && !io.FIFO_empty;
   assign last_word = word_q == WW'(C_WORDS_PER_ROW - 1);

   // FIFO data arrives the cycle after the pop, so the mask write trails by two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         word_q      <= '0;
         drain_q     <= 1'b0;
         rd_q        <= 1'b0;
         mask_data_q <= '0;
         mask_wr_q   <= 1'b0;
         underflow_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         rd_q      <= fifo_rd;
         mask_wr_q <= rd_q;
         if (rd_q) mask_data_q <= io.FIFO_dout;
         case (state_q)
            S_IDLE: if (io.Subc_start) begin
               state_q     <= S_READ;
               row_q       <= '0;
               word_q      <= '0;
               underflow_q <= 1'b0;
            end
            S_READ: if (fifo_rd) begin
               word_q <= last_word ? '0 : word_q + 1'b1;
               if (last_word) state_q <= S_DRAIN;
            end else if (word_q != '0) begin
               underflow_q <= 1'b1;
            end
            // drain_q toggles twice per visit, so it re-enters at zero
            S_DRAIN: begin
               drain_q <= !drain_q;
               if (drain_q) state_q <= S_LATCH;
            end
            S_LATCH: if (row_q == RW'(C_NUM_ROWS - 1)) begin
               state_q <= S_DONE;
               cnt_q   <= cnt_q + 32'd1;
            end else begin
               row_q   <= row_q + 1'b1;
               state_q <= S_READ;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign io.FIFO_rd   = fifo_rd;
   assign io.Mask_data = mask_data_q;
   assign io.Mask_wr   = mask_wr_q;
   assign io.Row_latch = state_q == S_LATCH;
   assign io.Subc_done = state_q == S_DONE;
   assign io.Busy      = state_q != S_IDLE;
   assign io.Underflow = underflow_q;
   assign io.CntSubc   = cnt_q;

endmodule
